// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs req/ack with instruction memory and
// hands fetched words to decode through a one-entry valid/ready buffer with branch redirect.
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  pc_out,
   input  logic [ADDR_W-1:0]  pc_plus,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_data,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               branch_en,
   input  logic [ADDR_W-1:0]  branch_target
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic                 req_q, req_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [INSTR_W-1:0]   iout_q, iout_d;
   logic [ADDR_W-1:0]    ipc_q, ipc_d;
   logic                 valid_q, valid_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         iout_q  <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         iout_q  <= iout_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      iout_d  = iout_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;

      unique case (state_q)
         IDLE: begin
            req_d   = 1'b1;
            state_d = REQ;
            if (branch_en) begin
               pc_d   = branch_target;
               addr_d = branch_target;
            end else begin
               addr_d = pc_q;
            end
         end

         REQ: begin
            if (branch_en) begin
               pc_d = branch_target;
               // An ack on the redirect edge is dropped and the new address issued at once;
               // without an ack the old request stays outstanding and must be drained.
               if (mem_ack) begin
                  addr_d = branch_target;
               end else begin
                  state_d = FLUSH;
               end
            end else if (mem_ack) begin
               iout_d  = mem_data;
               ipc_d   = addr_q;
               valid_d = 1'b1;
               req_d   = 1'b0;
               pc_d    = pc_plus;
               state_d = HOLD;
            end
         end

         HOLD: begin
            if (branch_en) begin
               valid_d = 1'b0;
               pc_d    = branch_target;
               req_d   = 1'b1;
               addr_d  = branch_target;
               state_d = REQ;
            end else if (valid_q && instr_ready) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = REQ;
            end
         end

         FLUSH: begin
            if (branch_en) begin
               pc_d = branch_target;
            end
            if (mem_ack) begin
               addr_d  = branch_en ? branch_target : pc_q;
               state_d = REQ;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign pc_out      = pc_q;
   assign mem_req     = req_q;
   assign mem_addr    = addr_q;
   assign instr_out   = iout_q;
   assign instr_pc    = ipc_q;
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// compared cycle by cycle against a flag-based transaction model.
module tb_fetch_unit;

   localparam int unsigned AW = 8;
   localparam int unsigned IW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_ack = 1'b0;
   logic          instr_ready = 1'b0;
   logic          branch_en = 1'b0;
   logic [IW-1:0] mem_data = '0;
   logic [AW-1:0] branch_target = '0;
   logic [AW-1:0] pc_out, pc_plus, mem_addr, instr_pc;
   logic          mem_req, instr_valid;
   logic [IW-1:0] instr_out;

   always #5 clk = ~clk;

   // Stand-in for the PC incrementer adder (b tied to 1).
   assign pc_plus = pc_out + 8'd1;

   fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(8'h00)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_out        (pc_out),
      .pc_plus       (pc_plus),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_data      (mem_data),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .branch_en     (branch_en),
      .branch_target (branch_target)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Model: idle / request-outstanding / outstanding-is-stale / word-buffered flags.
   bit          m_idle, m_req, m_stale, m_valid;
   int unsigned m_pc, m_addr, m_out, m_ipc;
   int unsigned seen[$];
   int unsigned mem_wait = 0;
   int unsigned max_lat  = 0;
   bit          dead_seen = 0;

   task automatic model(input bit r, input bit a, input int unsigned d,
                        input bit rdy, input bit b, input int unsigned t);
      if (r) begin
         m_idle = 1; m_req = 0; m_stale = 0; m_valid = 0;
         m_pc = 0; m_addr = 0; m_out = 0; m_ipc = 0;
      end else if (m_idle) begin
         if (b) m_pc = t;
         m_addr = m_pc; m_req = 1; m_idle = 0;
      end else if (m_req) begin
         if (b) begin
            m_pc = t;
            if (a) begin m_addr = t; m_stale = 0; end
            else m_stale = 1;
         end else if (a) begin
            if (m_stale) begin
               m_addr = m_pc; m_stale = 0;
            end else begin
               m_out = d % 65536; m_ipc = m_addr; m_valid = 1; m_req = 0;
               m_pc = (m_pc + 1) % 256;
            end
         end
      end else if (b || rdy) begin
         m_valid = 0; m_req = 1;
         if (b) m_pc = t;
         m_addr = m_pc;
      end
   endtask

   task automatic step(input bit r, input bit a, input int unsigned d,
                       input bit rdy, input bit b, input int unsigned t);
      @(negedge clk);
      rst = r; mem_ack = a; mem_data = IW'(d); instr_ready = rdy;
      branch_en = b; branch_target = AW'(t);
      if (!r && m_valid && rdy) seen.push_back(m_ipc);
      model(r, a, d, rdy, b, t);
      if (r || a) mem_wait = $urandom_range(max_lat, 0);
      @(posedge clk);
      #1;
      check("pc_out", pc_out, m_pc);
      check("mem_req", mem_req, m_req);
      check("mem_addr", mem_addr, m_addr);
      check("instr_valid", instr_valid, m_valid);
      check("instr_out", instr_out, m_out);
      check("instr_pc", instr_pc, m_ipc);
      if (m_valid) check("word_of_pc", instr_out, 32'h1000 + m_ipc);
      if (instr_valid && instr_out == 16'hDEAD) dead_seen = 1;
   endtask

   // Memory responder: acks the outstanding request after its drawn latency.
   task automatic cycle(input bit rdy, input bit b, input int unsigned t);
      bit a;
      a = 0;
      if (m_req) begin
         if (mem_wait == 0) a = 1;
         else mem_wait--;
      end
      step(0, a, 32'h1000 + m_addr, rdy, b, t);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
   endtask

   task automatic run_until_req(input int unsigned addr, output bit ok);
      ok = 0;
      for (int i = 0; i < 64 && !ok; i++) begin
         cycle(1, 0, 0);
         if (m_req && !m_stale && m_addr == addr) ok = 1;
      end
   endtask

   task automatic run_until_seen(input int unsigned n, output bit ok);
      ok = 0;
      for (int i = 0; i < 64 && !ok; i++) begin
         cycle(1, 0, 0);
         if (seen.size() >= n) ok = 1;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      int unsigned n0;
      int unsigned exp_wrap[4];

      // Reset and sequential fetch with zero-wait memory
      max_lat = 0;
      do_reset();
      check("rst_pc", pc_out, 0);
      check("rst_req", mem_req, 0);
      seen.delete();
      for (int i = 0; i < 12; i++) cycle(1, 0, 0);
      check("seq_count", seen.size(), 5);
      for (int i = 0; i < 4; i++)
         if (i < seen.size()) check("seq_pc", seen[i], i);

      // Back-pressure
      do_reset();
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0);
         check("bp_req_low", mem_req, 0);
         check("bp_valid", instr_valid, 1);
         check("bp_word", instr_out, 16'h1000);
      end
      cycle(1, 0, 0);
      check("bp_next_req", mem_req, 1);
      check("bp_next_addr", mem_addr, 1);

      // Branch in REQ without ack, stale ack of 0xDEAD two cycles later
      do_reset();
      seen.delete();
      run_until_req(3, ok);
      check("reach_req3", ok, 1);
      step(0, 0, 0, 1, 1, 32'h40);
      check("flush_old_addr", mem_addr, 3);
      step(0, 0, 0, 1, 0, 0);
      step(0, 1, 32'hDEAD, 1, 0, 0);
      check("flush_req", mem_req, 1);
      check("flush_new_addr", mem_addr, 32'h40);
      n0 = seen.size();
      run_until_seen(n0 + 1, ok);
      check("flush_seen", ok, 1);
      if (ok) check("flush_pc", seen[n0], 32'h40);
      check("no_dead", dead_seen, 0);

      // Branch coincident with ack in REQ
      do_reset();
      seen.delete();
      run_until_req(2, ok);
      check("reach_req2", ok, 1);
      step(0, 1, 32'hBEEF, 1, 1, 32'h80);
      check("br_ack_valid", instr_valid, 0);
      check("br_ack_addr", mem_addr, 32'h80);
      n0 = seen.size();
      run_until_seen(n0 + 1, ok);
      check("br_ack_seen", ok, 1);
      if (ok) check("br_ack_pc", seen[n0], 32'h80);

      // Branch coincident with ready in HOLD
      cycle(0, 0, 0);
      check("hold_valid", instr_valid, 1);
      n0 = seen.size();
      step(0, 0, 0, 1, 1, 32'h20);
      check("hold_consumed", seen.size(), n0 + 1);
      check("hold_br_valid", instr_valid, 0);
      check("hold_br_addr", mem_addr, 32'h20);
      run_until_seen(n0 + 2, ok);
      check("hold_br_seen", ok, 1);
      if (ok) check("hold_br_pc", seen[n0 + 1], 32'h20);

      // Wrap-around
      do_reset();
      step(0, 0, 0, 1, 1, 32'hFE);
      seen.delete();
      run_until_seen(4, ok);
      check("wrap_seen", ok, 1);
      exp_wrap = '{32'hFE, 32'hFF, 32'h00, 32'h01};
      for (int i = 0; i < 4; i++)
         if (i < seen.size()) check("wrap_pc", seen[i], exp_wrap[i]);

      // Reset while flushing
      do_reset();
      run_until_req(1, ok);
      check("reach_req1", ok, 1);
      step(0, 0, 0, 1, 1, 32'h55);
      check("pre_rst_req", mem_req, 1);
      step(1, 0, 0, 0, 0, 0);
      check("flush_rst_pc", pc_out, 0);
      check("flush_rst_req", mem_req, 0);
      check("flush_rst_valid", instr_valid, 0);
      cycle(1, 0, 0);
      check("post_rst_req", mem_req, 1);
      check("post_rst_addr", mem_addr, 0);

      // Randomized traffic
      max_lat = 2;
      for (int i = 0; i < 3000; i++) begin
         bit rdy, b, a;
         int unsigned t;
         if ($urandom_range(299, 0) == 0) begin
            step(1, 0, 0, 0, 0, 0);
         end else begin
            rdy = ($urandom_range(3, 0) != 0);
            b   = ($urandom_range(15, 0) == 0);
            t   = $urandom_range(255, 0);
            a   = 0;
            if (m_req) begin
               if (mem_wait == 0) a = 1;
               else mem_wait--;
            end else begin
               a = ($urandom_range(49, 0) == 0);
            end
            step(0, a, 32'h1000 + m_addr, rdy, b, t);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
